// File: rtl/mcu_cmd_pkg.sv
// mcu_cmd_pkg: shared definitions for the MCU command controller.
//   - opcode constants for the command bytes
//   - FSM state encoding
//   - default memory address width
// Optional macro MCU_CMD_CHECKSUM_EN adds the CHK opcode and its argument state.
package mcu_cmd_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 16;

    localparam logic [7:0] OpSetAddr = 8'h01;
    localparam logic [7:0] OpWrite   = 8'h02;
    localparam logic [7:0] OpLed     = 8'h03;
    localparam logic [7:0] OpClrErr  = 8'h04;
`ifdef MCU_CMD_CHECKSUM_EN
    localparam logic [7:0] OpChk     = 8'h05;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StAddrLo,
        StAddrHi,
        StWrite,
`ifdef MCU_CMD_CHECKSUM_EN
        StChkArg,
`endif
        StLedArg
    } state_e;

endpackage

// File: rtl/mcu_cmd_fifo.sv
// mcu_cmd_fifo: small synchronous FIFO for buffered memory writes.
// Ports:
//   sysclk, rst_n  clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata    write an entry; ignored while full
//   pop            remove the head entry; ignored while empty
//   rdata          head entry (valid while !empty)
//   full, empty    status flags, derived from registered pointers only
module mcu_cmd_fifo #(
    parameter int unsigned Width = 24,
    parameter int unsigned Depth = 4
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = $clog2(Depth);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PtrW:0]      wr_ptr_q;
    logic [PtrW:0]      rd_ptr_q;
    logic [Width-1:0]   mem_q [Depth];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign rdata = mem_q[rd_ptr_q[PtrW-1:0]];

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr_q <= wr_ptr_q + (PtrW + 1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr_q <= rd_ptr_q + (PtrW + 1)'(1);
            end
        end
    end

    // Storage needs no reset: entries are only visible through the pointers.
    always_ff @(posedge sysclk) begin
        if (push && !full) begin
            mem_q[wr_ptr_q[PtrW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/mcu_cmd_ctrl.sv
// mcu_cmd_ctrl: decodes a byte stream from an MCU bus into pixel-memory writes and
// a few control registers.
// Ports:
//   sysclk, rst_n                    clock, asynchronous active-low reset
//   rx_valid, rx_byte, rx_is_cmd     byte strobe, byte, command(1)/data(0) flag
//   mem_wr_en, mem_addr, mem_data    buffered write request (FIFO head)
//   mem_ready                        memory accepts the write this cycle
//   led                              LED register
//   busy                             command in progress or writes pending
//   err                              sticky protocol error
// Optional macro MCU_CMD_CHECKSUM_EN: enables opcode 0x05 (CHK), which compares a
// running XOR of accepted WRITE data bytes against its argument byte.
module mcu_cmd_ctrl
    import mcu_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic              rx_is_cmd,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    input  logic              mem_ready,
    output logic              led,
    output logic              busy,
    output logic              err
);

    localparam int unsigned EntryW = ADDR_W + 8;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        addr_lo_q;   // staged until the high byte arrives
    logic              led_q;
    logic              err_q;
`ifdef MCU_CMD_CHECKSUM_EN
    logic [7:0]        chk_q;
`endif

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic [EntryW-1:0] fifo_rdata;

    assign fifo_push = rx_valid && !rx_is_cmd && (state_q == StWrite) && !fifo_full;
    assign fifo_pop  = !fifo_empty && mem_ready;

    mcu_cmd_fifo #(
        .Width (EntryW),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .push   (fifo_push),
        .wdata  ({addr_q, rx_byte}),
        .pop    (fifo_pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign mem_wr_en = !fifo_empty;
    assign mem_addr  = fifo_rdata[EntryW-1:8];
    assign mem_data  = fifo_rdata[7:0];
    assign led       = led_q;
    assign err       = err_q;
    assign busy      = (state_q != StIdle) || !fifo_empty;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            addr_lo_q <= '0;
            led_q     <= 1'b0;
            err_q     <= 1'b0;
`ifdef MCU_CMD_CHECKSUM_EN
            chk_q     <= '0;
`endif
        end else if (rx_valid) begin
            if (rx_is_cmd) begin
                // Any command aborts whatever was in progress.
                case (rx_byte)
                    OpSetAddr: state_q <= StAddrLo;
                    OpWrite: begin
                        state_q <= StWrite;
`ifdef MCU_CMD_CHECKSUM_EN
                        chk_q   <= '0;
`endif
                    end
                    OpLed:     state_q <= StLedArg;
                    OpClrErr: begin
                        err_q   <= 1'b0;
                        state_q <= StIdle;
                    end
`ifdef MCU_CMD_CHECKSUM_EN
                    OpChk:     state_q <= StChkArg;
`endif
                    default: begin
                        err_q   <= 1'b1;
                        state_q <= StIdle;
                    end
                endcase
            end else begin
                case (state_q)
                    StIdle: err_q <= 1'b1;
                    StAddrLo: begin
                        addr_lo_q <= rx_byte;
                        state_q   <= StAddrHi;
                    end
                    StAddrHi: begin
                        addr_q  <= ADDR_W'({rx_byte, addr_lo_q});
                        state_q <= StIdle;
                    end
                    StWrite: begin
                        // Full is judged on pre-pop occupancy; the byte is lost.
                        if (fifo_full) begin
                            err_q <= 1'b1;
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
`ifdef MCU_CMD_CHECKSUM_EN
                            chk_q  <= chk_q ^ rx_byte;
`endif
                        end
                    end
                    StLedArg: begin
                        if (rx_byte == 8'hFF) begin
                            led_q <= 1'b1;
                        end else if (rx_byte == 8'h00) begin
                            led_q <= 1'b0;
                        end
                        state_q <= StIdle;
                    end
`ifdef MCU_CMD_CHECKSUM_EN
                    StChkArg: begin
                        if (chk_q != rx_byte) begin
                            err_q <= 1'b1;
                        end
                        state_q <= StIdle;
                    end
`endif
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule
